// File: rtl/ex_mem.sv
// ex_mem: EX->MEM pipeline register with a 2-entry skid buffer.
// ex_ready comes straight from state flops, so mem_ready never reaches
// ex_ready combinationally. Also exposes the EX/MEM forwarding source and a
// saturating back-pressure counter.
module ex_mem #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    output logic              mem_valid,
    input  logic              mem_ready,
    input  logic [PC_W-1:0]   EX_pc,
    input  logic              EX_w_ena,
    input  logic [REG_W-1:0]  EX_w_addr,
    input  logic [DATA_W-1:0] EX_alu_res,
    input  logic [DATA_W-1:0] EX_data2,
    input  logic [2:0]        EX_memwop,
    input  logic [2:0]        EX_memrop,
    input  logic              EX_mem_ena,
    input  logic              EX_mem_wr,
    output logic [PC_W-1:0]   MEM_pc,
    output logic              MEM_w_ena,
    output logic [REG_W-1:0]  MEM_w_addr,
    output logic [DATA_W-1:0] MEM_alu_res,
    output logic [DATA_W-1:0] MEM_data2,
    output logic [2:0]        MEM_memwop,
    output logic [2:0]        MEM_memrop,
    output logic              MEM_mem_ena,
    output logic              MEM_mem_wr,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  bp_cycles
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              w_ena;
        logic [REG_W-1:0]  w_addr;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] data2;
        logic [2:0]        memwop;
        logic [2:0]        memrop;
        logic              mem_ena;
        logic              mem_wr;
    } payload_t;

    // Encoding: bit 0 = main valid, bit 1 = skid valid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        MAIN_HOLD,
        MAIN_IN,
        MAIN_SKID
    } main_sel_e;

    state_e           state_q, state_d;
    main_sel_e        main_sel;
    logic             skid_load;
    payload_t         in_pl;
    payload_t         main_q, main_d;
    payload_t         skid_q, skid_d;
    logic [CNT_W-1:0] bp_q, bp_d;
    logic             main_valid;
    logic             accept;
    logic             pop;

    assign main_valid = state_q[0];
    assign ex_ready   = ~state_q[1];
    assign mem_valid  = main_valid & ~flush;
    assign accept     = ex_valid & ex_ready;
    assign pop        = mem_valid & mem_ready;

    // Pack the EX-side inputs into one payload word.
    always_comb begin
        in_pl         = '0;
        in_pl.pc      = EX_pc;
        in_pl.w_ena   = EX_w_ena;
        in_pl.w_addr  = EX_w_addr;
        in_pl.alu_res = EX_alu_res;
        in_pl.data2   = EX_data2;
        in_pl.memwop  = EX_memwop;
        in_pl.memrop  = EX_memrop;
        in_pl.mem_ena = EX_mem_ena;
        in_pl.mem_wr  = EX_mem_wr;
    end

    // Occupancy next-state and payload-load decisions; flush overrides all.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        main_sel  = MAIN_HOLD;
        skid_load = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_sel = MAIN_IN;
                        state_d  = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_sel = MAIN_IN;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // ex_ready is low here, so nothing can be accepted.
                    if (pop) begin
                        main_sel = MAIN_SKID;
                        state_d  = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Payload muxes: registers change only on the listed transitions.
    always_comb begin
        case (main_sel)
            MAIN_IN:   main_d = in_pl;
            MAIN_SKID: main_d = skid_q;
            default:   main_d = main_q;
        endcase
        skid_d = skid_load ? in_pl : skid_q;
    end

    // Back-pressure counter next value, saturating at all-ones.
    always_comb begin
        bp_d = bp_q;
        if (ex_valid && !ex_ready && (bp_q != '1)) begin
            bp_d = bp_q + CNT_W'(1);
        end
    end

    // State, payload and counter registers.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: the payload registers are reset too, not just the valid bits,
        // so MEM_* read as a harmless no-op (no write, no access) after reset.
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            bp_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments, so all flops sample the values
            // from before this edge regardless of statement order.
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            bp_q    <= bp_d;
        end
    end

    assign MEM_pc      = main_q.pc;
    assign MEM_w_ena   = main_q.w_ena;
    assign MEM_w_addr  = main_q.w_addr;
    assign MEM_alu_res = main_q.alu_res;
    assign MEM_data2   = main_q.data2;
    assign MEM_memwop  = main_q.memwop;
    assign MEM_memrop  = main_q.memrop;
    assign MEM_mem_ena = main_q.mem_ena;
    assign MEM_mem_wr  = main_q.mem_wr;

    assign fwd_valid = main_valid & main_q.w_ena & (main_q.w_addr != '0) & ~flush;
    assign fwd_addr  = main_q.w_addr;
    assign fwd_data  = main_q.alu_res;
    assign bp_cycles = bp_q;

endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: directed bench for ex_mem with hand-computed expectations.
module tb_ex_mem;

    localparam int DATA_W = 64;
    localparam int PC_W   = 64;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              flush;
    logic              ex_valid;
    logic              ex_ready;
    logic              mem_valid;
    logic              mem_ready;
    logic [PC_W-1:0]   EX_pc;
    logic              EX_w_ena;
    logic [REG_W-1:0]  EX_w_addr;
    logic [DATA_W-1:0] EX_alu_res;
    logic [DATA_W-1:0] EX_data2;
    logic [2:0]        EX_memwop;
    logic [2:0]        EX_memrop;
    logic              EX_mem_ena;
    logic              EX_mem_wr;
    logic [PC_W-1:0]   MEM_pc;
    logic              MEM_w_ena;
    logic [REG_W-1:0]  MEM_w_addr;
    logic [DATA_W-1:0] MEM_alu_res;
    logic [DATA_W-1:0] MEM_data2;
    logic [2:0]        MEM_memwop;
    logic [2:0]        MEM_memrop;
    logic              MEM_mem_ena;
    logic              MEM_mem_wr;
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_addr;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  bp_cycles;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] PA = 64'h0000_0000_8000_0100;
    localparam logic [63:0] PB = 64'h0000_0000_8000_0104;
    localparam logic [63:0] PC = 64'h0000_0000_8000_0108;
    localparam logic [63:0] PD = 64'h0000_0000_DEAD_0000;

    ex_mem #(
        .DATA_W(DATA_W), .PC_W(PC_W), .REG_W(REG_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .EX_pc(EX_pc), .EX_w_ena(EX_w_ena), .EX_w_addr(EX_w_addr),
        .EX_alu_res(EX_alu_res), .EX_data2(EX_data2),
        .EX_memwop(EX_memwop), .EX_memrop(EX_memrop),
        .EX_mem_ena(EX_mem_ena), .EX_mem_wr(EX_mem_wr),
        .MEM_pc(MEM_pc), .MEM_w_ena(MEM_w_ena), .MEM_w_addr(MEM_w_addr),
        .MEM_alu_res(MEM_alu_res), .MEM_data2(MEM_data2),
        .MEM_memwop(MEM_memwop), .MEM_memrop(MEM_memrop),
        .MEM_mem_ena(MEM_mem_ena), .MEM_mem_wr(MEM_mem_wr),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .bp_cycles(bp_cycles)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer an instruction; the side fields are derived from pc so that
    // ordering errors show up in MEM_data2 as well as MEM_pc.
    task automatic offer(input logic [63:0] pc, input logic w_ena,
                         input logic [4:0] w_addr, input logic [63:0] alu);
        ex_valid   = 1'b1;
        EX_pc      = pc;
        EX_w_ena   = w_ena;
        EX_w_addr  = w_addr;
        EX_alu_res = alu;
        EX_data2   = ~pc;
        EX_memwop  = 3'd3;
        EX_memrop  = 3'd5;
        EX_mem_ena = 1'b1;
        EX_mem_wr  = 1'b1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        ex_valid = 1'b0; EX_pc = '0; EX_w_ena = 1'b0; EX_w_addr = '0;
        EX_alu_res = '0; EX_data2 = '0; EX_memwop = '0; EX_memrop = '0;
        EX_mem_ena = 1'b0; EX_mem_wr = 1'b0;

        // ---------------- reset state
        tick(); tick();
        check("rst_ex_ready", 64'(ex_ready), 64'd1);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_mem_pc", 64'(MEM_pc), 64'd0);
        check("rst_ctl", 64'({MEM_w_ena, MEM_mem_ena, MEM_mem_wr, MEM_memwop, MEM_memrop}), 64'd0);
        check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        check("rst_bp", 64'(bp_cycles), 64'd0);
        reset = 1'b1;
        tick();

        // ---------------- streaming, mem_ready = 1
        mem_ready = 1'b1;
        offer(64'h8000_0000, 1'b1, 5'd1, 64'h10); settle();
        check("str_rdy0", 64'(ex_ready), 64'd1);
        tick();
        offer(64'h8000_0004, 1'b1, 5'd2, 64'h20); settle();
        check("str_pc1", 64'(MEM_pc), 64'h8000_0000);
        check("str_v1", 64'(mem_valid), 64'd1);
        check("str_rdy1", 64'(ex_ready), 64'd1);
        check("str_side1", 64'({MEM_memwop, MEM_memrop, MEM_mem_ena, MEM_mem_wr}), 64'({3'd3, 3'd5, 1'b1, 1'b1}));
        tick();
        offer(64'h8000_0008, 1'b1, 5'd3, 64'h30); settle();
        check("str_pc2", 64'(MEM_pc), 64'h8000_0004);
        check("str_rdy2", 64'(ex_ready), 64'd1);
        tick();
        ex_valid = 1'b0; settle();
        check("str_pc3", 64'(MEM_pc), 64'h8000_0008);
        check("str_d3", 64'(MEM_data2), ~64'h8000_0008);
        check("str_v3", 64'(mem_valid), 64'd1);
        tick();
        check("str_drained", 64'(mem_valid), 64'd0);

        // ---------------- back-pressure A, B, C
        mem_ready = 1'b0;
        offer(PA, 1'b0, 5'd0, 64'hA); settle();
        check("bp_rdy_a", 64'(ex_ready), 64'd1);
        tick();
        offer(PB, 1'b0, 5'd0, 64'hB); settle();
        check("bp_rdy_b", 64'(ex_ready), 64'd1);
        check("bp_head_a", 64'(MEM_pc), PA);
        tick();
        offer(PC, 1'b0, 5'd0, 64'hC); settle();
        check("bp_full_rdy", 64'(ex_ready), 64'd0);
        check("bp_cnt0", 64'(bp_cycles), 64'd0);
        tick();
        settle();
        check("bp_cnt1", 64'(bp_cycles), 64'd1);
        check("bp_hold_a", 64'(MEM_pc), PA);
        tick();
        mem_ready = 1'b1; settle();
        check("bp_cnt2", 64'(bp_cycles), 64'd2);
        check("bp_pop_a", 64'(MEM_pc), PA);
        check("bp_pop_a_d", 64'(MEM_data2), ~PA);
        tick();
        settle();
        check("bp_rdy_after", 64'(ex_ready), 64'd1);
        check("bp_pop_b", 64'(MEM_pc), PB);
        check("bp_pop_b_d", 64'(MEM_data2), ~PB);
        check("bp_cnt3", 64'(bp_cycles), 64'd3);
        tick();
        ex_valid = 1'b0; settle();
        check("bp_pop_c", 64'(MEM_pc), PC);
        check("bp_pop_c_v", 64'(mem_valid), 64'd1);
        tick();
        check("bp_empty", 64'(mem_valid), 64'd0);
        check("bp_cnt_end", 64'(bp_cycles), 64'd3);

        // ---------------- flush while FULL with D offered
        mem_ready = 1'b0;
        offer(PA, 1'b1, 5'd7, 64'h1); tick();
        offer(PB, 1'b1, 5'd8, 64'h2); tick();
        offer(PD, 1'b1, 5'd9, 64'hD); flush = 1'b1; settle();
        check("fl_mem_valid", 64'(mem_valid), 64'd0);
        check("fl_fwd_valid", 64'(fwd_valid), 64'd0);
        check("fl_rdy", 64'(ex_ready), 64'd0);
        tick();
        flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1; settle();
        check("fl_empty_v", 64'(mem_valid), 64'd0);
        check("fl_empty_rdy", 64'(ex_ready), 64'd1);
        check("fl_cnt", 64'(bp_cycles), 64'd4);
        tick();
        check("fl_no_d", 64'(mem_valid), 64'd0);

        // ---------------- forwarding
        mem_ready = 1'b0;
        offer(PA, 1'b1, 5'd5, 64'h1234); tick();
        ex_valid = 1'b0; settle();
        check("fw_valid", 64'(fwd_valid), 64'd1);
        check("fw_addr", 64'(fwd_addr), 64'd5);
        check("fw_data", 64'(fwd_data), 64'h1234);
        mem_ready = 1'b1;
        offer(PA, 1'b1, 5'd0, 64'h1234); tick();
        ex_valid = 1'b0; mem_ready = 1'b0; settle();
        check("fw_x0_head", 64'(mem_valid), 64'd1);
        check("fw_x0_valid", 64'(fwd_valid), 64'd0);
        check("fw_x0_data", 64'(fwd_data), 64'h1234);
        flush = 1'b1; tick();
        flush = 1'b0;

        // ---------------- asynchronous reset with FULL occupancy
        offer(PA, 1'b1, 5'd3, 64'h5); tick();
        offer(PB, 1'b1, 5'd4, 64'h6); tick();
        offer(PC, 1'b1, 5'd6, 64'h7); settle();
        check("ar_full", 64'(ex_ready), 64'd0);
        tick();
        check("ar_cnt_pre", 64'(bp_cycles), 64'd5);
        #1 reset = 1'b0;
        #1;
        check("ar_mem_valid", 64'(mem_valid), 64'd0);
        check("ar_rdy", 64'(ex_ready), 64'd1);
        check("ar_w_ena", 64'(MEM_w_ena), 64'd0);
        check("ar_cnt", 64'(bp_cycles), 64'd0);
        ex_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // ---------------- counter saturation (CNT_W = 4)
        mem_ready = 1'b0;
        offer(PA, 1'b0, 5'd0, 64'h0); tick();
        offer(PB, 1'b0, 5'd0, 64'h0); tick();
        offer(PC, 1'b0, 5'd0, 64'h0);
        for (int i = 0; i < 14; i++) tick();
        check("sat_14", 64'(bp_cycles), 64'd14);
        for (int i = 0; i < 6; i++) tick();
        check("sat_15", 64'(bp_cycles), 64'd15);
        check("sat_head", 64'(MEM_pc), PA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
Pipeline stage register between EX and MEM in the 5-stage core. It captures the ALU result, store data, register-write control and memory control for one instruction, and hands it to MEM using a valid/ready handshake. A 2-entry skid buffer keeps ex_ready fully registered, so there is no combinational path from mem_ready to ex_ready. It also supplies the EX/MEM forwarding source to the hazard unit and counts back-pressure cycles.

Parameters:
DATA_W, 64, width of ALU result and store data
PC_W, 64, width of PC
REG_W, 5, register address width
CNT_W, 32, width of the back-pressure counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
flush  in  1  synchronous kill of all held entries (branch/trap redirect)
ex_valid  in  1  EX presents a valid instruction
ex_ready  out  1  stage can accept this cycle (registered)
mem_valid  out  1  head entry valid toward MEM
mem_ready  in  1  MEM accepts the head entry
EX_pc  in  PC_W  instruction PC
EX_w_ena  in  1  register write enable
EX_w_addr  in  REG_W  destination register
EX_alu_res  in  DATA_W  ALU result or effective address
EX_data2  in  DATA_W  store data
EX_memwop  in  3  store width op
EX_memrop  in  3  load width/sign op
EX_mem_ena  in  1  memory access enable
EX_mem_wr  in  1  1 = write, 0 = read
MEM_pc, MEM_w_ena, MEM_w_addr, MEM_alu_res, MEM_data2, MEM_memwop, MEM_memrop, MEM_mem_ena, MEM_mem_wr  out  (same widths as the EX_* inputs)  head-entry payload
fwd_valid  out  1  head entry will write a nonzero register
fwd_addr  out  REG_W  equals MEM_w_addr
fwd_data  out  DATA_W  equals MEM_alu_res
bp_cycles  out  CNT_W  saturating count of cycles with ex_valid & ~ex_ready

Behaviour:
- Storage: a main entry (head) and a skid entry, each holding a payload and a valid bit.
- Occupancy states:
  - EMPTY: neither entry valid.
  - ONE: main valid.
  - FULL: main and skid valid.
- Combinational signals:
  - ex_ready = ~skid_valid (register output only).
  - mem_valid = main_valid & ~flush.
  - accept = ex_valid & ex_ready.
  - pop = mem_valid & mem_ready.
- Transitions on rising edge, when flush = 0:
  - EMPTY: accept -> main <= input, go to ONE.
  - ONE: accept & pop -> main <= input, stay ONE. accept & ~pop -> skid <= input, go to FULL. ~accept & pop -> EMPTY. Otherwise hold.
  - FULL: pop -> main <= skid, skid_valid <= 0, go to ONE. Otherwise hold. accept cannot occur in FULL.
- Ordering: strictly FIFO. The skid entry never overtakes main.
- flush = 1 has highest priority:
  - Both valid bits clear on the next edge, and any input offered that cycle is discarded.
  - mem_valid is 0 in the flush cycle itself, so no pop occurs.
  - ex_ready is 1 on the cycle after.
- Payload registers load only on the transitions listed. Otherwise they hold their values, including while invalid. Downstream must qualify all payload with mem_valid.
- fwd_valid = main_valid & MEM_w_ena & (MEM_w_addr != 0) & ~flush.
- bp_cycles:
  - Increments by 1 each cycle with ex_valid & ~ex_ready.
  - Saturates at all-ones and does not wrap.
  - Is not cleared by flush.
- Reset (asynchronous assert, deassert sampled on clock):
  - Both valid bits = 0, so ex_ready = 1 and mem_valid = 0.
  - All MEM_* outputs = 0: w_ena disabled, mem_ena disabled, mem_wr = read, ops = none, pc = 0.
  - fwd_valid = 0 and bp_cycles = 0.
  - Skid payload = 0.
  - Reset asserted mid-transfer drops everything immediately, with no clock edge needed.
- Latency: an accepted instruction is visible on MEM_* on the next cycle. Throughput is 1 per cycle while mem_ready = 1.

Test Plan:
- Reset: assert reset = 0 mid-run with FULL occupancy -> immediately mem_valid = 0, ex_ready = 1, MEM_w_ena = 0, bp_cycles = 0.
- Streaming: mem_ready = 1, send pc 0x80000000, 0x80000004 and 0x80000008 on consecutive cycles -> MEM_pc shows them on cycles 1, 2 and 3; ex_ready stays 1.
- Back-pressure: mem_ready = 0, send A then B -> state FULL, ex_ready = 0 from cycle 2. C is held by EX, and bp_cycles increments each cycle C waits. Raise mem_ready -> A, B, C are delivered in order, with no loss or duplication.
- Flush: in FULL, pulse flush together with ex_valid = 1 carrying D -> mem_valid = 0 that cycle, EMPTY next cycle, and D never appears.
- Forwarding: head entry has w_ena = 1, w_addr = 5, alu_res = 0x1234 -> fwd_valid = 1, fwd_addr = 5, fwd_data = 0x1234. The same entry with w_addr = 0 -> fwd_valid = 0.
- Saturation: with CNT_W = 4, hold back-pressure for 20 cycles -> bp_cycles stops at 15.
